// File: rtl/pipe_ctrl_pkg.sv
// pipe_ctrl_pkg: shared types for the pipeline stall/flush sequencer.
//   state_e    - sequencer state, encoding visible on pipe_ctrl.state_o
//   STG_*      - index of each pipeline boundary register in the en/flush vectors
//   pipe_ctl_t - PC enable plus per-boundary enable and bubble-flush bits
package pipe_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_RUN      = 2'd0,
    ST_MEM_WAIT = 2'd1,
    ST_HALTED   = 2'd2,
    ST_ERR      = 2'd3
  } state_e;

  localparam int unsigned NUM_STG    = 4;
  localparam int unsigned STG_IF_ID  = 0;
  localparam int unsigned STG_ID_EX  = 1;
  localparam int unsigned STG_EX_MEM = 2;
  localparam int unsigned STG_MEM_WB = 3;

  typedef struct packed {
    logic               pc_en;
    logic [NUM_STG-1:0] en;
    logic [NUM_STG-1:0] flush;
  } pipe_ctl_t;

  // Every register advancing, no bubbles.
  function automatic pipe_ctl_t ctl_normal();
    pipe_ctl_t c;
    c.pc_en = 1'b1;
    c.en    = '1;
    c.flush = '0;
    return c;
  endfunction

endpackage

// File: rtl/pipe_ctrl_sat.sv
// sat_counter: up-counter that sticks at all-ones.
//   clk, rst_n : clock, asynchronous active-low reset (count -> 0)
//   clr_i      : clear to 0; with inc_i in the same cycle the count becomes 1
//   inc_i      : increment unless already all-ones
//   cnt_o      : current count
module sat_counter #(
  parameter int unsigned W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clr_i,
  input  logic         inc_i,
  output logic [W-1:0] cnt_o
);

  logic [W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) cnt_d = '0;
    if (inc_i && (cnt_d != '1)) cnt_d = cnt_d + 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

  assign cnt_o = cnt_q;

endmodule

// File: rtl/pipe_ctrl.sv
// pipe_ctrl: stall/flush sequencer for the 5-stage core.
//   Inputs : load_use_i, redirect_i, trap_i, imem_ready_i, dmem_req_i,
//            dmem_ack_i, halt_i, resume_i (hazard and control requests)
//   Outputs: pc_en_o and *_en_o / *_flush_o for IF/ID, ID/EX, EX/MEM, MEM/WB;
//            state_o (RUN/MEM_WAIT/HALTED/ERR), timeout_o (sticky watchdog
//            error), stall_cnt_o (saturating count of stalled cycles)
module pipe_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int unsigned TIMEOUT     = 200,
  parameter int unsigned TIMEOUT_W   = 8,
  parameter int unsigned STALL_CNT_W = 16
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   load_use_i,
  input  logic                   redirect_i,
  input  logic                   trap_i,
  input  logic                   imem_ready_i,
  input  logic                   dmem_req_i,
  input  logic                   dmem_ack_i,
  input  logic                   halt_i,
  input  logic                   resume_i,
  output logic                   pc_en_o,
  output logic                   if_id_en_o,
  output logic                   id_ex_en_o,
  output logic                   ex_mem_en_o,
  output logic                   mem_wb_en_o,
  output logic                   if_id_flush_o,
  output logic                   id_ex_flush_o,
  output logic                   ex_mem_flush_o,
  output logic                   mem_wb_flush_o,
  output logic [1:0]             state_o,
  output logic                   timeout_o,
  output logic [STALL_CNT_W-1:0] stall_cnt_o
);

  localparam logic [TIMEOUT_W-1:0] TIMEOUT_V = TIMEOUT_W'(TIMEOUT);

  state_e                 state_q, state_d;
  logic                   timeout_q, timeout_d;
  pipe_ctl_t              ctl;
  logic                   mem_stall;
  logic                   wd_clr, wd_inc;
  logic [TIMEOUT_W-1:0]   wd_cnt;
  logic                   stall_inc;

  always_comb begin
    ctl       = ctl_normal();
    state_d   = state_q;
    timeout_d = timeout_q;
    mem_stall = 1'b0;
    wd_clr    = 1'b1;
    wd_inc    = 1'b0;
    unique case (state_q)
      ST_RUN, ST_MEM_WAIT: begin
        // A request already waiting only needs the ack; a fresh one stalls
        // unless acked in the same cycle.
        mem_stall = (state_q == ST_MEM_WAIT) ? !dmem_ack_i
                                             : (dmem_req_i && !dmem_ack_i);
        if (mem_stall) begin
          ctl.pc_en             = 1'b0;
          ctl.en                = '0;
          ctl.en[STG_MEM_WB]    = 1'b1;
          ctl.flush[STG_MEM_WB] = 1'b1;
          if (state_q == ST_RUN) begin
            state_d = ST_MEM_WAIT;
            wd_inc  = 1'b1;            // clear+inc loads 1
          end else if (wd_cnt == TIMEOUT_V) begin
            state_d   = ST_ERR;
            timeout_d = 1'b1;
            wd_clr    = 1'b0;
          end else begin
            wd_clr = 1'b0;
            wd_inc = 1'b1;
          end
        end else begin
          state_d = ST_RUN;
          if (trap_i) begin
            ctl.flush[STG_IF_ID]  = 1'b1;
            ctl.flush[STG_ID_EX]  = 1'b1;
            ctl.flush[STG_EX_MEM] = 1'b1;
          end else if (halt_i) begin
            ctl.pc_en          = 1'b0;
            ctl.en[STG_IF_ID]  = 1'b0;
            ctl.en[STG_ID_EX]  = 1'b0;
            ctl.en[STG_EX_MEM] = 1'b0;
            state_d            = ST_HALTED;
          end else if (redirect_i) begin
            ctl.flush[STG_IF_ID] = 1'b1;
            ctl.flush[STG_ID_EX] = 1'b1;
          end else if (load_use_i) begin
            ctl.pc_en            = 1'b0;
            ctl.en[STG_IF_ID]    = 1'b0;
            ctl.flush[STG_ID_EX] = 1'b1;
          end else if (!imem_ready_i) begin
            ctl.pc_en            = 1'b0;
            ctl.flush[STG_IF_ID] = 1'b1;
          end
        end
      end
      ST_HALTED: begin
        ctl = '0;
        if (resume_i) state_d = ST_RUN;
      end
      ST_ERR: begin
        ctl = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_RUN;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      timeout_q <= timeout_d;
    end
  end

  sat_counter #(.W(TIMEOUT_W)) u_watchdog (
    .clk   (clk),
    .rst_n (rst_n),
    .clr_i (wd_clr),
    .inc_i (wd_inc),
    .cnt_o (wd_cnt)
  );

  assign stall_inc = ((state_q == ST_RUN) || (state_q == ST_MEM_WAIT)) && !ctl.pc_en;

  sat_counter #(.W(STALL_CNT_W)) u_stall_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .clr_i (1'b0),
    .inc_i (stall_inc),
    .cnt_o (stall_cnt_o)
  );

  // Enables/flushes are held low for the whole time reset is asserted.
  assign pc_en_o        = rst_n & ctl.pc_en;
  assign if_id_en_o     = rst_n & ctl.en[STG_IF_ID];
  assign id_ex_en_o     = rst_n & ctl.en[STG_ID_EX];
  assign ex_mem_en_o    = rst_n & ctl.en[STG_EX_MEM];
  assign mem_wb_en_o    = rst_n & ctl.en[STG_MEM_WB];
  assign if_id_flush_o  = rst_n & ctl.flush[STG_IF_ID];
  assign id_ex_flush_o  = rst_n & ctl.flush[STG_ID_EX];
  assign ex_mem_flush_o = rst_n & ctl.flush[STG_EX_MEM];
  assign mem_wb_flush_o = rst_n & ctl.flush[STG_MEM_WB];
  assign state_o        = state_q;
  assign timeout_o      = timeout_q;

endmodule

// File: tb/tb_pipe_ctrl.sv
// tb_pipe_ctrl: scoreboard bench for pipe_ctrl. A behavioural model predicts
// each cycle's outputs from the applied inputs; predictions are queued and
// compared against the DUT at the falling clock edge.
module tb_pipe_ctrl;

  localparam int unsigned TO = 5;
  localparam int unsigned SW = 16;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          load_use_i, redirect_i, trap_i, imem_ready_i;
  logic          dmem_req_i, dmem_ack_i, halt_i, resume_i;
  logic          pc_en_o, if_id_en_o, id_ex_en_o, ex_mem_en_o, mem_wb_en_o;
  logic          if_id_flush_o, id_ex_flush_o, ex_mem_flush_o, mem_wb_flush_o;
  logic [1:0]    state_o;
  logic          timeout_o;
  logic [SW-1:0] stall_cnt_o;

  pipe_ctrl #(.TIMEOUT(TO), .TIMEOUT_W(8), .STALL_CNT_W(SW)) u_dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .load_use_i     (load_use_i),
    .redirect_i     (redirect_i),
    .trap_i         (trap_i),
    .imem_ready_i   (imem_ready_i),
    .dmem_req_i     (dmem_req_i),
    .dmem_ack_i     (dmem_ack_i),
    .halt_i         (halt_i),
    .resume_i       (resume_i),
    .pc_en_o        (pc_en_o),
    .if_id_en_o     (if_id_en_o),
    .id_ex_en_o     (id_ex_en_o),
    .ex_mem_en_o    (ex_mem_en_o),
    .mem_wb_en_o    (mem_wb_en_o),
    .if_id_flush_o  (if_id_flush_o),
    .id_ex_flush_o  (id_ex_flush_o),
    .ex_mem_flush_o (ex_mem_flush_o),
    .mem_wb_flush_o (mem_wb_flush_o),
    .state_o        (state_o),
    .timeout_o      (timeout_o),
    .stall_cnt_o    (stall_cnt_o)
  );

  always #5 clk = ~clk;

  // en = {pc, if_id, id_ex, ex_mem, mem_wb}; fl = {if_id, id_ex, ex_mem, mem_wb}
  typedef struct {
    logic [4:0]    en;
    logic [3:0]    fl;
    logic [1:0]    st;
    logic          to;
    logic [SW-1:0] sc;
  } exp_t;

  exp_t sb_q[$];
  int   n_chk  = 0;
  int   n_pass = 0;

  // Model state: 0 RUN, 1 MEM_WAIT, 2 HALTED, 3 ERR
  int            m_state = 0;
  int            m_wd    = 0;
  logic [SW-1:0] m_stall = '0;
  logic          m_to    = 1'b0;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
  endtask

  task automatic idle_inputs();
    load_use_i = 0; redirect_i = 0; trap_i = 0; imem_ready_i = 1;
    dmem_req_i = 0; dmem_ack_i = 0; halt_i = 0; resume_i = 0;
  endtask

  // Called at posedge+1 with inputs already applied; returns at next posedge+1.
  task automatic tick();
    exp_t e, x;
    int   nxt;
    logic stall_now;
    e.en = 5'b11111; e.fl = 4'b0000; nxt = m_state; stall_now = 1'b0;
    if (m_state == 0 || m_state == 1) begin
      stall_now = (m_state == 0) ? (dmem_req_i && !dmem_ack_i) : !dmem_ack_i;
      if (stall_now) begin
        e.en = 5'b00001; e.fl = 4'b0001;
        nxt  = (m_state == 1 && m_wd == TO) ? 3 : 1;
      end else begin
        nxt = 0;
        if (trap_i)             e.fl = 4'b1110;
        else if (halt_i)        begin e.en = 5'b00001; nxt = 2; end
        else if (redirect_i)    e.fl = 4'b1100;
        else if (load_use_i)    begin e.en = 5'b00111; e.fl = 4'b0100; end
        else if (!imem_ready_i) begin e.en = 5'b01111; e.fl = 4'b1000; end
      end
    end else begin
      e.en = '0; e.fl = '0;
      if (m_state == 2 && resume_i) nxt = 0;
    end
    e.st = 2'(m_state); e.to = m_to; e.sc = m_stall;
    sb_q.push_back(e);

    @(negedge clk);
    x = sb_q.pop_front();
    check_val("en", 32'({pc_en_o, if_id_en_o, id_ex_en_o, ex_mem_en_o, mem_wb_en_o}), 32'(x.en));
    check_val("flush", 32'({if_id_flush_o, id_ex_flush_o, ex_mem_flush_o, mem_wb_flush_o}), 32'(x.fl));
    check_val("state", 32'(state_o), 32'(x.st));
    check_val("timeout", 32'(timeout_o), 32'(x.to));
    check_val("stall_cnt", 32'(stall_cnt_o), 32'(x.sc));

    if (m_state <= 1 && !e.en[4] && m_stall != '1) m_stall = m_stall + 1'b1;
    if (stall_now) m_wd = (m_state == 0) ? 1 : m_wd + 1;
    else           m_wd = 0;
    if (nxt == 3) m_to = 1'b1;
    m_state = nxt;
    @(posedge clk); #1;
  endtask

  // Asserts reset away from the clock edge with inputs left as they are.
  task automatic do_reset();
    @(negedge clk); #2;
    rst_n = 1'b0; #1;
    check_val("rst_en", 32'({pc_en_o, if_id_en_o, id_ex_en_o, ex_mem_en_o, mem_wb_en_o}), 32'd0);
    check_val("rst_flush", 32'({if_id_flush_o, id_ex_flush_o, ex_mem_flush_o, mem_wb_flush_o}), 32'd0);
    check_val("rst_state", 32'(state_o), 32'd0);
    check_val("rst_timeout", 32'(timeout_o), 32'd0);
    check_val("rst_stall_cnt", 32'(stall_cnt_o), 32'd0);
    m_state = 0; m_wd = 0; m_stall = '0; m_to = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
  endtask

  initial begin
    idle_inputs();
    rst_n = 1'b1;
    @(posedge clk); #1;
    do_reset();

    // Idle run
    for (int i = 0; i < 10; i++) tick();

    // Load-use stall, then load-use suppressed by redirect
    load_use_i = 1; tick();
    load_use_i = 0; tick();
    load_use_i = 1; redirect_i = 1; tick();
    idle_inputs(); tick(); tick();

    // Data memory wait, ack after the stall
    dmem_req_i = 1;
    for (int i = 0; i < 3; i++) tick();
    dmem_ack_i = 1; tick();
    idle_inputs(); tick(); tick();

    // Request acked in the same cycle does not stall; fetch stall still wins below it
    dmem_req_i = 1; dmem_ack_i = 1; imem_ready_i = 0; tick();
    idle_inputs(); tick();

    // Trap and redirect while waiting; trap wins on the ack cycle
    dmem_req_i = 1; tick();
    trap_i = 1; redirect_i = 1; tick(); tick();
    dmem_ack_i = 1; tick();
    idle_inputs(); tick();

    // Halt on ack cycle from MEM_WAIT, then resume
    dmem_req_i = 1; tick();
    dmem_ack_i = 1; halt_i = 1; tick();
    idle_inputs(); tick(); tick();
    resume_i = 1; tick();
    idle_inputs(); tick();

    // Halt from RUN, resume winning over simultaneous halt
    halt_i = 1; tick();
    halt_i = 0; tick(); tick();
    halt_i = 1; resume_i = 1; tick();
    idle_inputs(); tick(); tick();

    // Watchdog timeout, sticky error, recovery by reset
    dmem_req_i = 1;
    for (int i = 0; i < 6; i++) tick();
    dmem_req_i = 0; resume_i = 1; tick(); tick();
    do_reset();
    idle_inputs(); tick();

    // Reset mid-MEM_WAIT and mid-HALTED
    dmem_req_i = 1; tick(); tick();
    do_reset();
    idle_inputs(); tick();
    halt_i = 1; tick(); halt_i = 0; tick();
    do_reset();
    tick();

    // Random mix
    for (int i = 0; i < 300; i++) begin
      load_use_i   = ($urandom_range(0, 3) == 0);
      redirect_i   = ($urandom_range(0, 5) == 0);
      trap_i       = ($urandom_range(0, 7) == 0);
      imem_ready_i = ($urandom_range(0, 3) != 0);
      dmem_req_i   = ($urandom_range(0, 2) == 0);
      dmem_ack_i   = ($urandom_range(0, 1) == 0);
      halt_i       = ($urandom_range(0, 15) == 0);
      resume_i     = ($urandom_range(0, 3) == 0);
      tick();
      if (m_state == 3) do_reset();
    end
    idle_inputs();
    do_reset();

    // Stall counter saturation
    load_use_i = 1;
    while (m_stall < 16'hFFFE) tick();
    for (int i = 0; i < 5; i++) tick();
    check_val("stall_sat", 32'(stall_cnt_o), 32'h0000_FFFF);
    idle_inputs(); tick();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
